sdram_cmd_arbiter: RTL and testbench

- Parametrised SDRAM command arbiter; next generation of the single-writer controller top.
- Sits between init, auto-refresh and NUM_CH user channels (e.g. write/read engines) and the SDRAM pins.
- Gives refresh priority, round-robin among channels, preempts a channel at a burst boundary when refresh is due, then resumes it.
- DQ tristate stays at the chip top; this block drives only dq_out/dq_oe.

---
 rtl/sdram_pkg.sv | 19 +
 rtl/sdram_cmd_arbiter_rr_pick.sv | 33 +++
 rtl/sdram_cmd_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and the arbiter state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sdram_pkg;

    // Commands are packed {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    // One-hot so each state test is a single flop bit.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ARBIT = 4'b0010,
        ST_AREF  = 4'b0100,
        ST_GRANT = 4'b1000
    } arb_state_t;

endpackage

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// Round-robin pick: first requester after last_id, wrapping past NUM_CH-1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid=0 when no channel requests.
// Ports: req (per-channel request), last_id (previous winner),
//        sel (chosen index), valid (some channel was chosen).
module rr_pick #(
    parameter  int NUM_CH = 2,
    localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   last_id,
    output logic [ID_W-1:0]   sel,
    output logic              valid
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester after last_id is the final (winning) assignment.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_id) + i) % NUM_CH;
            if (req[idx]) begin
                sel   = ID_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: init, then refresh-first, round-robin user channels.
// Latency: grants one cycle after request; pin mux is zero-latency from state.
// Backpressure: granted channel holds the bus until ch_end, or yields at ch_break when refresh is due.
// Ports: init_* (init sequencer), refr_* (auto-refresh engine, refr_en grant),
//        ch_* (packed per-channel buses, ch0 in LSBs; ch_en one-hot grant, grant_id index),
//        sdram_* (command/address pins), dq_out/dq_oe (write data to the pad tristate).
module sdram_cmd_arbiter
    import sdram_pkg::*;
#(
    parameter  int ADDR_W = 12,
    parameter  int BANK_W = 2,
    parameter  int DATA_W = 16,
    parameter  int NUM_CH = 2,
    localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     init_done,
    input  logic [3:0]               init_cmd,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic                     refr_req,
    input  logic                     refr_end,
    input  logic [3:0]               refr_cmd,
    input  logic [ADDR_W-1:0]        refr_addr,
    output logic                     refr_en,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_end,
    input  logic [NUM_CH-1:0]        ch_break,
    input  logic [4*NUM_CH-1:0]      ch_cmd,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [BANK_W*NUM_CH-1:0] ch_bank,
    input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_drive,
    output logic [NUM_CH-1:0]        ch_en,
    output logic [ID_W-1:0]          grant_id,
    output logic                     sdram_cs_n,
    output logic                     sdram_ras_n,
    output logic                     sdram_cas_n,
    output logic                     sdram_we_n,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [BANK_W-1:0]        sdram_bank,
    output logic [DATA_W-1:0]        dq_out,
    output logic                     dq_oe
);

    arb_state_t        state, state_nx;
    logic              refr_en_nx;
    logic [NUM_CH-1:0] ch_en_nx;
    logic [ID_W-1:0]   grant_id_nx;
    logic [ID_W-1:0]   last_id, last_id_nx;
    logic              pend_valid, pend_valid_nx;
    logic [ID_W-1:0]   pend_id, pend_id_nx;

    logic [ID_W-1:0]   rr_sel;
    logic              rr_valid;
    logic              pend_hit;
    logic [ID_W-1:0]   sel_id;
    logic              sel_vld;
    logic [3:0]        pin_cmd;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .req     (ch_req),
        .last_id (last_id),
        .sel     (rr_sel),
        .valid   (rr_valid)
    );

    // A preempted channel resumes ahead of round-robin, but only if it is
    // still requesting; otherwise round-robin decides in the same cycle.
    assign pend_hit = pend_valid & ch_req[pend_id];
    assign sel_id   = pend_hit ? pend_id : rr_sel;
    assign sel_vld  = pend_hit | rr_valid;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            refr_en    <= 1'b0;
            ch_en      <= '0;
            grant_id   <= '0;
            last_id    <= ID_W'(NUM_CH - 1);
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else begin
            state      <= state_nx;
            refr_en    <= refr_en_nx;
            ch_en      <= ch_en_nx;
            grant_id   <= grant_id_nx;
            last_id    <= last_id_nx;
            pend_valid <= pend_valid_nx;
            pend_id    <= pend_id_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        refr_en_nx    = refr_en;
        ch_en_nx      = ch_en;
        grant_id_nx   = grant_id;
        last_id_nx    = last_id;
        pend_valid_nx = pend_valid;
        pend_id_nx    = pend_id;
        unique case (state)
            ST_IDLE: begin
                if (init_done) state_nx = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (refr_req) begin
                    // Pending channel survives the refresh and resumes after it.
                    state_nx   = ST_AREF;
                    refr_en_nx = 1'b1;
                end else begin
                    pend_valid_nx = 1'b0;
                    if (sel_vld) begin
                        state_nx    = ST_GRANT;
                        ch_en_nx    = NUM_CH'(1) << sel_id;
                        grant_id_nx = sel_id;
                    end
                end
            end
            ST_AREF: begin
                if (refr_end) begin
                    state_nx   = ST_ARBIT;
                    refr_en_nx = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ch_end[grant_id]) begin
                    state_nx   = ST_ARBIT;
                    ch_en_nx   = '0;
                    last_id_nx = grant_id;
                end else if (refr_req && ch_break[grant_id]) begin
                    // Yield for refresh; last_id untouched so fairness is unaffected.
                    state_nx      = ST_ARBIT;
                    ch_en_nx      = '0;
                    pend_valid_nx = 1'b1;
                    pend_id_nx    = grant_id;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pin_cmd    = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        dq_oe      = 1'b0;
        dq_out     = '0;
        unique case (state)
            ST_IDLE: begin
                pin_cmd    = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                pin_cmd    = refr_cmd;
                sdram_addr = refr_addr;
            end
            ST_GRANT: begin
                pin_cmd    = ch_cmd[4*grant_id +: 4];
                sdram_addr = ch_addr[ADDR_W*grant_id +: ADDR_W];
                sdram_bank = ch_bank[BANK_W*grant_id +: BANK_W];
                dq_oe      = ch_drive[grant_id];
                if (ch_drive[grant_id]) dq_out = ch_wdata[DATA_W*grant_id +: DATA_W];
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter with NUM_CH=2.
// Latency: each vector is driven, clocked once, then outputs checked 1ns after the edge.
// Backpressure: n/a.
module tb_sdram_cmd_arbiter;

    localparam int M_I = 0;  // expect IDLE pins
    localparam int M_A = 1;  // expect ARBIT pins (NOP)
    localparam int M_R = 2;  // expect AREF pins, refr_en
    localparam int M_G = 3;  // expect GRANT pins for channel g

    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [11:0] INIT_ADDR = 12'h400;
    localparam logic [3:0]  REFR_CMD  = 4'b0001;
    localparam logic [11:0] REFR_ADDR = 12'h123;
    localparam logic [3:0]  C_CMD  [2] = '{4'b0101, 4'b0011};
    localparam logic [11:0] C_ADDR [2] = '{12'hA00, 12'hB11};
    localparam logic [1:0]  C_BANK [2] = '{2'd1, 2'd2};
    localparam logic [15:0] C_WD   [2] = '{16'hD000, 16'hD111};

    typedef struct {
        string      nm;
        logic       rst, ini, rr, re;
        logic [1:0] rq, en, bk, dr;
        int         m, g;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst, init_done, refr_req, refr_end;
    logic [1:0]  ch_req, ch_end, ch_break, ch_drive;
    logic        refr_en;
    logic [1:0]  ch_en;
    logic        grant_id;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [15:0] dq_out;
    logic        dq_oe;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 sys_clk = ~sys_clk;

    sdram_cmd_arbiter #(.ADDR_W(12), .BANK_W(2), .DATA_W(16), .NUM_CH(2)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .init_done   (init_done),
        .init_cmd    (INIT_CMD),
        .init_addr   (INIT_ADDR),
        .refr_req    (refr_req),
        .refr_end    (refr_end),
        .refr_cmd    (REFR_CMD),
        .refr_addr   (REFR_ADDR),
        .refr_en     (refr_en),
        .ch_req      (ch_req),
        .ch_end      (ch_end),
        .ch_break    (ch_break),
        .ch_cmd      ({C_CMD[1], C_CMD[0]}),
        .ch_addr     ({C_ADDR[1], C_ADDR[0]}),
        .ch_bank     ({C_BANK[1], C_BANK[0]}),
        .ch_wdata    ({C_WD[1], C_WD[0]}),
        .ch_drive    (ch_drive),
        .ch_en       (ch_en),
        .grant_id    (grant_id),
        .sdram_cs_n  (cs_n),
        .sdram_ras_n (ras_n),
        .sdram_cas_n (cas_n),
        .sdram_we_n  (we_n),
        .sdram_addr  (sdram_addr),
        .sdram_bank  (sdram_bank),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe)
    );

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    // Grants must never overlap, including refresh against a channel.
    always @(negedge sys_clk) begin
        chk("monitor", "grant_onehot0", 32'($onehot0({refr_en, ch_en})), 32'd1);
    end

    task automatic apply(input vec_t v);
        logic [3:0]  e_cmd;
        logic [11:0] e_addr;
        logic [1:0]  e_bank;
        logic        e_oe;
        sys_rst   = v.rst;
        init_done = v.ini;
        refr_req  = v.rr;
        refr_end  = v.re;
        ch_req    = v.rq;
        ch_end    = v.en;
        ch_break  = v.bk;
        ch_drive  = v.dr;
        @(posedge sys_clk);
        #1;
        e_cmd  = 4'b0111;
        e_addr = 12'h000;
        e_bank = 2'd0;
        e_oe   = 1'b0;
        case (v.m)
            M_I: begin e_cmd = INIT_CMD; e_addr = INIT_ADDR; end
            M_R: begin e_cmd = REFR_CMD; e_addr = REFR_ADDR; end
            M_G: begin
                e_cmd  = C_CMD[v.g];
                e_addr = C_ADDR[v.g];
                e_bank = C_BANK[v.g];
                e_oe   = v.dr[v.g];
            end
            default: ;
        endcase
        chk(v.nm, "refr_en",  32'(refr_en),  32'(v.m == M_R));
        chk(v.nm, "ch_en",    32'(ch_en),    (v.m == M_G) ? (32'd1 << v.g) : 32'd0);
        chk(v.nm, "grant_id", 32'(grant_id), 32'(v.g));
        chk(v.nm, "cmd",      32'({cs_n, ras_n, cas_n, we_n}), 32'(e_cmd));
        chk(v.nm, "addr",     32'(sdram_addr), 32'(e_addr));
        chk(v.nm, "bank",     32'(sdram_bank), 32'(e_bank));
        chk(v.nm, "dq_oe",    32'(dq_oe),    32'(e_oe));
        chk(v.nm, "dq_out",   32'(dq_out),   e_oe ? 32'(C_WD[v.g]) : 32'd0);
    endtask

    function automatic vec_t mk(input string nm, input logic rst, input logic ini, input logic rr,
                                input logic re, input logic [1:0] rq, input logic [1:0] en,
                                input logic [1:0] bk, input logic [1:0] dr, input int m, input int g);
        vec_t v;
        v.nm = nm; v.rst = rst; v.ini = ini; v.rr = rr; v.re = re;
        v.rq = rq; v.en = en; v.bk = bk; v.dr = dr; v.m = m; v.g = g;
        return v;
    endfunction

    task automatic s(input string nm, input logic rst, input logic ini, input logic rr,
                     input logic re, input logic [1:0] rq, input logic [1:0] en,
                     input logic [1:0] bk, input logic [1:0] dr, input int m, input int g);
        apply(mk(nm, rst, ini, rr, re, rq, en, bk, dr, m, g));
    endtask

    initial begin
        //                 name           rst  ini  rr   re   rq     en     bk     dr     mode g
        tbl.push_back(mk("reset0",       1,   0,   0,   0,   2'b00, 2'b00, 2'b00, 2'b00, M_I, 0));
        tbl.push_back(mk("reset1",       1,   0,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_I, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk("idle",     0,   0,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_I, 0));
        tbl.push_back(mk("init_done",    0,   1,   0,   0,   2'b00, 2'b00, 2'b00, 2'b00, M_A, 0));
        tbl.push_back(mk("rr_first0",    0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_G, 0));
        tbl.push_back(mk("drive0",       0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b01, M_G, 0));
        tbl.push_back(mk("end0",         0,   1,   0,   0,   2'b11, 2'b01, 2'b00, 2'b00, M_A, 0));
        tbl.push_back(mk("rr_alt1",      0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_G, 1));
        tbl.push_back(mk("drive1",       0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b10, M_G, 1));
        tbl.push_back(mk("end1",         0,   1,   0,   0,   2'b11, 2'b10, 2'b00, 2'b00, M_A, 1));
        tbl.push_back(mk("rr_alt0",      0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_G, 0));
        tbl.push_back(mk("end0b",        0,   1,   0,   0,   2'b10, 2'b01, 2'b00, 2'b00, M_A, 0));
        tbl.push_back(mk("solo0",        0,   1,   0,   0,   2'b01, 2'b00, 2'b00, 2'b00, M_G, 0));
        tbl.push_back(mk("ignore_other", 0,   1,   1,   0,   2'b01, 2'b10, 2'b10, 2'b00, M_G, 0));
        tbl.push_back(mk("break0",       0,   1,   1,   0,   2'b01, 2'b00, 2'b01, 2'b00, M_A, 0));
        tbl.push_back(mk("aref",         0,   1,   1,   0,   2'b01, 2'b00, 2'b00, 2'b00, M_R, 0));
        tbl.push_back(mk("aref_hold",    0,   1,   1,   0,   2'b11, 2'b11, 2'b11, 2'b00, M_R, 0));
        tbl.push_back(mk("refr_end",     0,   1,   0,   1,   2'b11, 2'b00, 2'b00, 2'b00, M_A, 0));
        tbl.push_back(mk("resume0",      0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_G, 0));
        tbl.push_back(mk("end0c",        0,   1,   0,   0,   2'b11, 2'b01, 2'b00, 2'b00, M_A, 0));
        tbl.push_back(mk("rr1",          0,   1,   0,   0,   2'b11, 2'b00, 2'b00, 2'b00, M_G, 1));
        tbl.push_back(mk("end1b",        0,   1,   0,   0,   2'b00, 2'b10, 2'b00, 2'b00, M_A, 1));
        tbl.push_back(mk("arbit_idle",   0,   1,   0,   0,   2'b00, 2'b00, 2'b00, 2'b00, M_A, 1));
        tbl.push_back(mk("refr_vs_ch0",  0,   1,   1,   0,   2'b01, 2'b00, 2'b00, 2'b00, M_R, 1));
        tbl.push_back(mk("refr_hold",    0,   1,   1,   0,   2'b01, 2'b00, 2'b00, 2'b00, M_R, 1));
        tbl.push_back(mk("refr_end2",    0,   1,   0,   1,   2'b01, 2'b00, 2'b00, 2'b00, M_A, 1));
        tbl.push_back(mk("after_refr0",  0,   1,   0,   0,   2'b01, 2'b00, 2'b00, 2'b00, M_G, 0));
        tbl.push_back(mk("end0d",        0,   1,   0,   0,   2'b00, 2'b01, 2'b00, 2'b00, M_A, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Preempted ch1 resumes ahead of ch0 even though round-robin favours ch0.
        s("pre_g1",      0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, M_G, 1);
        s("pre_end1",    0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, M_A, 1);
        s("pre_g1b",     0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, M_G, 1);
        s("pre_break1",  0, 1, 1, 0, 2'b11, 2'b00, 2'b10, 2'b00, M_A, 1);
        s("pre_aref",    0, 1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, M_R, 1);
        s("pre_rend",    0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, M_A, 1);
        s("pre_resume1", 0, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, M_G, 1);
        s("pre_end1b",   0, 1, 0, 0, 2'b11, 2'b10, 2'b00, 2'b00, M_A, 1);

        // End and break together: end wins, no pending resume, ch0 goes next.
        s("eb_g1",       0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, M_G, 1);
        s("eb_both",     0, 1, 1, 0, 2'b11, 2'b10, 2'b10, 2'b00, M_A, 1);
        s("eb_aref",     0, 1, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, M_R, 1);
        s("eb_rend",     0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, M_A, 1);
        s("eb_next0",    0, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, M_G, 0);

        // Reset while ch1 drives DQ; afterwards last_id is back to NUM_CH-1.
        s("rs_end0",     0, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, M_A, 0);
        s("rs_g1",       0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, M_G, 1);
        s("rs_drive1",   0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, M_G, 1);
        s("rs_reset",    1, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, M_I, 0);
        s("rs_idle",     0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b10, M_I, 0);
        s("rs_init",     0, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, M_A, 0);
        s("rs_first0",   0, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b01, M_G, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
